// File: rtl/spectrum_mag_sq_pkg.sv
// Shared types and default sizing for the power-spectrum block.
package spectrum_mag_sq_pkg;

  localparam int unsigned DEF_FFT_SIZE   = 4096;
  localparam int unsigned DEF_REAL_INPUT = 1;
  localparam int unsigned DEF_BIN_WIDTH  = 32;
  localparam int unsigned DEF_OUT_WIDTH  = 32;
  localparam int unsigned DEF_OUT_SHIFT  = 16;

  // Per-beat sideband travelling alongside the datapath.
  typedef struct packed {
    logic valid;
    logic last;
  } side_t;

endpackage

// File: rtl/mag_sq_pipe.sv
// Stall-able square / sum / shift / saturate datapath with a valid/last sideband.
module mag_sq_pipe
  import spectrum_mag_sq_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = DEF_BIN_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  side_t                       in_side,
  input  logic signed [BIN_WIDTH-1:0] in_re,
  input  logic signed [BIN_WIDTH-1:0] in_im,
  output side_t                       out_side,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [OUT_WIDTH/8-1:0]      out_keep
);

  localparam int unsigned SW = 2 * BIN_WIDTH;
  localparam int unsigned KW = OUT_WIDTH / 8;

  side_t                       s0_side;
  side_t                       s1_side;
  logic signed [BIN_WIDTH-1:0] s0_re;
  logic signed [BIN_WIDTH-1:0] s0_im;
  logic [SW-1:0]               s1_sq_re;
  logic [SW-1:0]               s1_sq_im;

  logic signed [SW-1:0]        re_ext;
  logic signed [SW-1:0]        im_ext;
  logic [SW-1:0]               sum;
  logic [SW-1:0]               shifted;
  logic [OUT_WIDTH-1:0]        sat;

  // Squares of a signed value are non-negative and fit in SW bits.
  always_comb begin
    re_ext  = SW'(s0_re);
    im_ext  = SW'(s0_im);
    sum     = s1_sq_re + s1_sq_im;
    shifted = sum >> OUT_SHIFT;
    sat     = ((shifted >> OUT_WIDTH) != '0) ? '1 : shifted[OUT_WIDTH-1:0];
  end

  // Whole pipe moves as one; bubbles are overwritten only when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_side  <= '0;
      s0_re    <= '0;
      s0_im    <= '0;
      s1_side  <= '0;
      s1_sq_re <= '0;
      s1_sq_im <= '0;
      out_side <= '0;
      out_data <= '0;
      out_keep <= '0;
    end else if (en) begin
      s0_side  <= in_side;
      s0_re    <= in_re;
      s0_im    <= in_im;
      s1_side  <= s0_side;
      s1_sq_re <= $unsigned(re_ext * re_ext);
      s1_sq_im <= $unsigned(im_ext * im_ext);
      out_side <= s1_side;
      out_data <= sat;
      out_keep <= {KW{s1_side.valid}};
    end
  end

endmodule

// File: rtl/spectrum_mag_sq.sv
// AXI-Stream power spectrum |X|^2 with half-spectrum drop for real input and frame checking.
module spectrum_mag_sq
  import spectrum_mag_sq_pkg::*;
#(
  parameter int unsigned FFT_SIZE   = DEF_FFT_SIZE,
  parameter int unsigned REAL_INPUT = DEF_REAL_INPUT,
  parameter int unsigned BIN_WIDTH  = DEF_BIN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned OUT_SHIFT  = DEF_OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*BIN_WIDTH-1:0]   s_axis_tdata,
  input  logic [2*BIN_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [OUT_WIDTH-1:0]     m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     frame_err
);

  localparam int unsigned CW = $clog2(FFT_SIZE);
  localparam logic [CW-1:0] LAST_BIN  = CW'(FFT_SIZE - 1);
  localparam logic [CW-1:0] HALF_BIN  = CW'(FFT_SIZE / 2);
  localparam logic [CW-1:0] LAST_KEPT = (REAL_INPUT != 0) ? HALF_BIN : LAST_BIN;

  logic [CW-1:0] bin_cnt;
  logic          en;
  logic          accept;
  logic          at_last;
  logic          keep_bin;
  side_t         in_side;
  side_t         out_side;
  logic          unused_tkeep;

  assign unused_tkeep = ^s_axis_tkeep;

  // Global advance: everything moves unless the output beat is stuck.
  always_comb begin
    en            = ~m_axis_tvalid | m_axis_tready;
    accept        = s_axis_tvalid & en;
    at_last       = (bin_cnt == LAST_BIN);
    keep_bin      = (REAL_INPUT == 0) || (bin_cnt <= HALF_BIN);
    in_side.valid = accept & keep_bin;
    in_side.last  = accept & keep_bin & ((bin_cnt == LAST_KEPT) | s_axis_tlast);
  end

  assign s_axis_tready = en;

  // Bin counter realigns on either tlast or the natural frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      bin_cnt <= (s_axis_tlast || at_last) ? '0 : bin_cnt + CW'(1);
      if (s_axis_tlast != at_last) begin
        frame_err <= 1'b1;
      end
    end
  end

  mag_sq_pipe #(
    .BIN_WIDTH (BIN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_side  (in_side),
    .in_re    (s_axis_tdata[BIN_WIDTH-1:0]),
    .in_im    (s_axis_tdata[2*BIN_WIDTH-1:BIN_WIDTH]),
    .out_side (out_side),
    .out_data (m_axis_tdata),
    .out_keep (m_axis_tkeep)
  );

  assign m_axis_tvalid = out_side.valid;
  assign m_axis_tlast  = out_side.last;

endmodule

// File: doc/spectrum_mag_sq.md
# spectrum_mag_sq

Downstream consumer of the STFT wrapper's FFT output stream. Takes complex FFT bins one per beat over AXI-Stream and computes the power spectrum |X|² = re² + im². Scales the result by a fixed right shift and saturates it into an unsigned output word. For real-input frames it discards the redundant upper half of the spectrum. Output is a per-frame AXI-Stream of FFT_SIZE/2+1 power values (or FFT_SIZE values for complex input) that feeds the spectrogram DMA path.

## Interface
- FFT_SIZE, 4096, bins per frame; power of two, ≥ 8
- REAL_INPUT, 1, 1 = forward bins 0..FFT_SIZE/2 only; 0 = forward all bins
- BIN_WIDTH, 32, width of each signed real/imag component
- OUT_WIDTH, 32, width of the unsigned power output
- OUT_SHIFT, 16, right shift applied to the 2·BIN_WIDTH-bit sum before saturation
- clk  in  1  single clock domain
- reset  in  1  asynchronous, active-low reset
- s_axis_tdata  in  2·BIN_WIDTH  {im[BIN_WIDTH-1:0], re[BIN_WIDTH-1:0]}, two's complement
- s_axis_tkeep  in  2·BIN_WIDTH/8  ignored
- s_axis_tlast  in  1  last bin of an FFT frame
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  block can accept a beat
- m_axis_tdata  out  OUT_WIDTH  saturated power value
- m_axis_tkeep  out  OUT_WIDTH/8  all ones whenever m_axis_tvalid=1
- m_axis_tlast  out  1  last forwarded bin of the frame
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accepts the beat
- frame_err  out  1  sticky; set on any frame-length mismatch, cleared only by reset

## Operation
- Accepted input beat: s_axis_tvalid & s_axis_tready.
- bin_cnt (log2 FFT_SIZE bits):
  - Increments on each accepted beat.
  - Returns to 0 after an accepted beat that carries tlast or has bin_cnt = FFT_SIZE-1.
- Keep rule:
  - REAL_INPUT=1: the beat propagates iff bin_cnt ≤ FFT_SIZE/2.
  - REAL_INPUT=0: every beat propagates.
- Dropped beats are still accepted; they produce no output.
- Output tlast:
  - Set on the kept beat with bin_cnt = FFT_SIZE/2 (REAL_INPUT=1) or FFT_SIZE-1 (REAL_INPUT=0).
  - Also set on any kept beat whose input tlast is set (early tlast).
- Length errors (frame_err ← 1, realignment as in the bin_cnt rule above):
  - tlast with bin_cnt ≠ FFT_SIZE-1.
  - bin_cnt = FFT_SIZE-1 without tlast.
- Arithmetic:
  - re² and im² are each 2·BIN_WIDTH-bit unsigned values.
  - sum = re² + im² is 2·BIN_WIDTH bits; it cannot overflow, since the maximum is 2^(2·BIN_WIDTH-1).
  - Result = sum >> OUT_SHIFT, saturated to 2^OUT_WIDTH-1.
- Pipeline stages: S0 input register (re, im, keep, last) → S1 two squares → S2 sum, shift, saturate → output register.

## Timing
- Latency: 3 cycles from an accepted kept input beat to m_axis_tvalid, with no backpressure.
- Throughput: 1 beat/cycle.
- Global advance: en = ~m_axis_tvalid | m_axis_tready.
  - All stages and bin_cnt advance only when en=1.
  - s_axis_tready = en.
- Valid bits propagate with the data. A bubble can be overwritten only when en=1.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable.
- Reset (asynchronous assert, synchronous-safe release):
  - Clears all stage valids and bin_cnt.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, frame_err=0, s_axis_tready=1.
- Mid-frame reset: beats in flight are lost. The next accepted beat is bin 0.
- Simultaneous output handshake and new input: both complete in the same cycle.

## Structure
- Shared include fft_defs.vh: add the bin/power width macros (e.g. `MAG_OUT_WIDTH`, `MAG_BYTE_COUNT`) next to the existing AXI width macros.
- One natural sub-module: `mag_sq_pipe`, the stall-able 3-stage square/sum/shift/saturate datapath with a valid/last sideband.
- Top level holds bin_cnt, keep/tlast logic, frame_err and the handshake.
- Instantiated in the STFT top after the FFT wrapper's m_axis port.

## Test plan
- Bench uses FFT_SIZE=16, BIN_WIDTH=16, OUT_WIDTH=16, OUT_SHIFT=0 unless stated.
- Nominal frame, REAL_INPUT=1: 16 beats with re=bin, im=0 → 9 outputs 0,1,4,…,64; tlast only on the 9th; frame_err=0.
- Saturation: re=im=-32768 → sum 2^31; with OUT_SHIFT=0 output is 0xFFFF. With OUT_SHIFT=16 output is 0x8000.
- Backpressure: m_axis_tready toggled 1010… with a continuous input frame → no lost or duplicated beats; data stable while stalled; s_axis_tready low in stall cycles.
- Early tlast on bin 5 → outputs for bins 0..5, tlast on bin 5, frame_err=1. The next frame starts at bin 0 and produces 9 outputs.
- Missing tlast at bin 15 → frame_err=1. The following beat is treated as bin 0.
- Reset asserted after bin 7 with the pipeline full → m_axis_tvalid=0 immediately. After release, a full frame yields exactly 9 outputs.
